// File: rtl/inst_slot_arbiter_pkg.sv
// rtl/inst_slot_arbiter_pkg.sv - shared types and constants for the instruction slot arbiter
package inst_slot_arbiter_pkg;

   // Width of one instruction word carried through the arbiter
   localparam int INST_LENGTH   = 32;

   // Default number of consecutive beats one slot may hold the path
   localparam int MAX_BURST_DEF = 2;

   // IDLE: no slot owns the path; OWN: a slot is mid-burst
   typedef enum logic [0:0] {
      ARB_IDLE,
      ARB_OWN
   } arb_state_e;

endpackage

// File: rtl/Configurable_Multiplexer.sv
// rtl/Configurable_Multiplexer.sv - one-of-N data selector for the instruction slots
module Configurable_Multiplexer
   import inst_slot_arbiter_pkg::*;
#(
   parameter int INPUT_SLOT = 4,
   parameter int DATA_W     = INST_LENGTH,
   localparam int SW        = $clog2(INPUT_SLOT)
) (
   input  logic [SW-1:0]                      sel,
   input  logic [INPUT_SLOT-1:0][DATA_W-1:0]  data_in,
   output logic [DATA_W-1:0]                  data_out
);

   // Select the addressed slot; unused select codes (non-power-of-two) give zero
   always_comb begin
      data_out = '0;
      for (int i = 0; i < INPUT_SLOT; i++) begin
         if (sel == SW'(i)) begin
            data_out = data_in[i];
         end
      end
   end

endmodule

// File: rtl/inst_slot_arbiter.sv
// rtl/inst_slot_arbiter.sv - round-robin burst arbiter feeding a one-entry instruction buffer
module inst_slot_arbiter
   import inst_slot_arbiter_pkg::*;
#(
   parameter int INPUT_SLOT = 4,
   parameter int MAX_BURST  = MAX_BURST_DEF,
   localparam int SW        = $clog2(INPUT_SLOT)
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [INPUT_SLOT-1:0]                    req_valid,
   input  logic [INPUT_SLOT-1:0][INST_LENGTH-1:0]   req_inst,
   output logic [INPUT_SLOT-1:0]                    req_ready,
   output logic                                     out_valid,
   output logic [INST_LENGTH-1:0]                   out_inst,
   output logic [SW-1:0]                            out_slot,
   input  logic                                     out_ready,
   input  logic                                     flush
);

   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_e             state_q;
   logic [SW-1:0]          owner_q;
   logic [SW-1:0]          ptr_q;
   logic [BW-1:0]          burst_q;
   logic                   out_valid_q;
   logic [INST_LENGTH-1:0] out_inst_q;
   logic [SW-1:0]          out_slot_q;

   logic                   can_load;
   logic                   own_hold;
   logic [SW-1:0]          search_ptr;
   logic [SW:0]            pick;
   logic                   grant_valid;
   logic [SW-1:0]          grant_idx;
   logic [BW-1:0]          burst_d;
   logic [INST_LENGTH-1:0] mux_out;

   // Next slot index with wrap at INPUT_SLOT-1 (legal for non-power-of-two counts)
   function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
      return (s == SW'(INPUT_SLOT - 1)) ? '0 : s + 1'b1;
   endfunction

   // First valid slot at or after start, wrapping; MSB flags that one was found
   function automatic logic [SW:0] rr_pick(input logic [INPUT_SLOT-1:0] v,
                                           input logic [SW-1:0]         start);
      logic [SW:0] res;
      int          j;
      res = '0;
      for (int k = INPUT_SLOT - 1; k >= 0; k--) begin
         j = int'(start) + k;
         if (j >= INPUT_SLOT) j = j - INPUT_SLOT;
         if (v[SW'(j)]) res = {1'b1, SW'(j)};
      end
      return res;
   endfunction

   // Grant decision: owner keeps the path while valid, otherwise search round-robin
   always_comb begin
      can_load    = !out_valid_q || out_ready;
      own_hold    = (state_q == ARB_OWN) && req_valid[owner_q];
      search_ptr  = (state_q == ARB_OWN) ? slot_inc(owner_q) : ptr_q;
      pick        = rr_pick(req_valid, search_ptr);
      grant_valid = !rst && can_load && !flush && (own_hold || pick[SW]);
      grant_idx   = own_hold ? owner_q : pick[SW-1:0];
      burst_d     = burst_q + 1'b1;
      req_ready   = '0;
      if (grant_valid) req_ready[grant_idx] = 1'b1;
   end

   Configurable_Multiplexer #(
      .INPUT_SLOT (INPUT_SLOT),
      .DATA_W     (INST_LENGTH)
   ) u_mux (
      .sel      (grant_idx),
      .data_in  (req_inst),
      .data_out (mux_out)
   );

   // Arbitration FSM together with the output buffer it loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         burst_q     <= '0;
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_slot_q  <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         state_q     <= ARB_IDLE;
         burst_q     <= '0;
      end else if (can_load) begin
         out_valid_q <= grant_valid;
         if (grant_valid) begin
            out_inst_q <= mux_out;
            out_slot_q <= grant_idx;
         end
         if (own_hold) begin
            burst_q <= burst_d;
            if (burst_d == BW'(MAX_BURST)) begin
               ptr_q   <= slot_inc(owner_q);
               state_q <= ARB_IDLE;
            end
         end else if (grant_valid) begin
            burst_q <= BW'(1);
            if (MAX_BURST > 1) begin
               state_q <= ARB_OWN;
               owner_q <= grant_idx;
               ptr_q   <= search_ptr;
            end else begin
               state_q <= ARB_IDLE;
               ptr_q   <= slot_inc(grant_idx);
            end
         end else begin
            ptr_q   <= search_ptr;
            state_q <= ARB_IDLE;
            burst_q <= '0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_slot  = out_slot_q;

   a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_no_grant_full : assert property (@(posedge clk) disable iff (rst) !can_load |-> (req_ready == '0));
   a_out_stable    : assert property (@(posedge clk) disable iff (rst)
                        (out_valid_q && !out_ready) |=> ($stable(out_inst_q) && $stable(out_slot_q)));

endmodule

// File: tb/tb_inst_slot_arbiter.sv
// tb/tb_inst_slot_arbiter.sv - randomized and directed checks of inst_slot_arbiter against a queue-level model
module tb_inst_slot_arbiter;

   localparam int IL = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic out_ready = 1'b1;
   logic flush = 1'b0;

   logic [3:0]           v4;
   logic [3:0][IL-1:0]   i4;
   logic [3:0]           rr4;
   logic                 ov4;
   logic [IL-1:0]        oi4;
   logic [1:0]           os4;

   logic [2:0]           v3;
   logic [2:0][IL-1:0]   i3;
   logic [2:0]           rr3;
   logic                 ov3;
   logic [IL-1:0]        oi3;
   logic [1:0]           os3;

   always #5 clk = ~clk;

   inst_slot_arbiter #(.INPUT_SLOT(4), .MAX_BURST(2)) dut4 (
      .clk(clk), .rst(rst), .req_valid(v4), .req_inst(i4), .req_ready(rr4),
      .out_valid(ov4), .out_inst(oi4), .out_slot(os4), .out_ready(out_ready), .flush(flush));

   inst_slot_arbiter #(.INPUT_SLOT(3), .MAX_BURST(1)) dut3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_inst(i3), .req_ready(rr3),
      .out_valid(ov3), .out_inst(oi3), .out_slot(os3), .out_ready(out_ready), .flush(flush));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 'h%0h required 'h%0h at %0t", name, act, exp, $time);
   endtask

   // Model: owner = -1 means nobody holds the path
   typedef struct {
      int           ptr;
      int           owner;
      int           burst;
      bit           ov;
      logic [IL-1:0] oinst;
      int           oslot;
   } mst_t;

   function automatic mst_t m_rst();
      mst_t t;
      t.ptr = 0; t.owner = -1; t.burst = 0; t.ov = 1'b0; t.oinst = '0; t.oslot = 0;
      return t;
   endfunction

   function automatic int m_grant(mst_t s, logic [3:0] v, bit ordy, bit fl, int n);
      int start;
      if (fl || (s.ov && !ordy)) return -1;
      if (s.owner >= 0 && v[s.owner]) return s.owner;
      start = (s.owner >= 0) ? (s.owner + 1) % n : s.ptr;
      for (int k = 0; k < n; k++) if (v[(start + k) % n]) return (start + k) % n;
      return -1;
   endfunction

   function automatic mst_t m_step(mst_t s, logic [3:0] v, logic [3:0][IL-1:0] ins,
                                   bit ordy, bit fl, int n, int mb);
      mst_t t;
      int g;
      t = s;
      if (fl) begin
         t.ov = 1'b0; t.owner = -1; t.burst = 0;
         return t;
      end
      if (s.ov && !ordy) return t;
      g = m_grant(s, v, ordy, fl, n);
      if (s.owner >= 0 && g != s.owner) begin
         t.ptr = (s.owner + 1) % n; t.owner = -1; t.burst = 0;
      end
      t.ov = (g >= 0);
      if (g >= 0) begin
         t.oinst = ins[g];
         t.oslot = g;
         t.burst = (g == s.owner) ? s.burst + 1 : 1;
         if (t.burst >= mb) begin
            t.ptr = (g + 1) % n; t.owner = -1;
         end else begin
            t.owner = g;
         end
      end
      return t;
   endfunction

   mst_t m4, n4, m3, n3;
   bit   cap_en = 1'b0;
   int   cap4[$];
   int   cap3[$];
   logic [IL-1:0] capi4[$];

   always @(negedge clk) begin
      int g;
      logic [3:0]         v3x;
      logic [3:0][IL-1:0] i3x;
      v3x = {1'b0, v3};
      i3x = {IL'(0), i3};
      if (rst) begin
         m4 = m_rst();
         m3 = m_rst();
      end
      g = rst ? -1 : m_grant(m4, v4, out_ready, flush, 4);
      check("req_ready4", rr4, (g < 0) ? 0 : (1 << g));
      check("out_valid4", ov4, m4.ov);
      check("out_inst4", oi4, m4.oinst);
      check("out_slot4", os4, m4.oslot);
      n4 = rst ? m_rst() : m_step(m4, v4, i4, out_ready, flush, 4, 2);
      g = rst ? -1 : m_grant(m3, v3x, out_ready, flush, 3);
      check("req_ready3", rr3, (g < 0) ? 0 : (1 << g));
      check("out_valid3", ov3, m3.ov);
      check("out_inst3", oi3, m3.oinst);
      check("out_slot3", os3, m3.oslot);
      n3 = rst ? m_rst() : m_step(m3, v3x, i3x, out_ready, flush, 3, 1);
      if (cap_en) begin
         cap4.push_back((ov4 && out_ready) ? int'(os4) : -1);
         capi4.push_back(oi4);
         cap3.push_back((ov3 && out_ready) ? int'(os3) : -1);
      end
   end

   always @(posedge clk) begin
      m4 = n4;
      m3 = n3;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cap_clear();
      cap4.delete();
      cap3.delete();
      capi4.delete();
   endtask

   task automatic seq_first(input int q[$], output int f);
      f = -1;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i] != -1) f = i;
   endtask

   task automatic cmp_seq(string name, input int q[$], input int e[$]);
      int f;
      seq_first(q, f);
      for (int i = 0; i < e.size(); i++)
         check(name, (f >= 0 && f + i < q.size()) ? q[f + i] : -2, e[i]);
   endtask

   task automatic do_reset();
      v4 = '0; v3 = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_tags();
      for (int k = 0; k < 4; k++) i4[k] = IL'(32'hA0 + k);
      for (int k = 0; k < 3; k++) i3[k] = IL'(32'hA0 + k);
   endtask

   int e_fair4[$] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   int e_fair3[$] = '{0, 1, 2, 0, 1};
   int e_early[$] = '{1, 3, 3, -1};
   int e_bp[$]    = '{0, 0, 1, 1};
   int e_flush[$] = '{0, 0, 1, 1, 2, -1, 2, 2, 3};

   initial begin
      int f;
      m4 = m_rst(); n4 = m_rst(); m3 = m_rst(); n3 = m_rst();
      v4 = '1; v3 = '1; i4 = '0; i3 = '0;
      repeat (3) tick();
      check("rst_out_valid", ov4, 0);
      check("rst_out_inst", oi4, 0);
      check("rst_out_slot", os4, 0);
      check("rst_req_ready", rr4, 0);
      rst = 1'b0;

      repeat (1500) begin
         tick();
         rst       = ($urandom_range(99) == 0);
         flush     = ($urandom_range(19) == 0);
         out_ready = ($urandom_range(9) < 7);
         v4        = 4'($urandom);
         v3        = 3'($urandom);
         for (int k = 0; k < 4; k++) i4[k] = $urandom;
         for (int k = 0; k < 3; k++) i3[k] = $urandom;
      end

      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      load_tags();
      v4 = '1; v3 = '1;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("midrst_out_valid4", ov4, 0);
      check("midrst_req_ready4", rr4, 0);
      check("midrst_out_valid3", ov3, 0);
      tick();

      cap_clear();
      cap_en = 1'b1;
      rst = 1'b0;
      repeat (12) tick();
      cap_en = 1'b0;
      cmp_seq("fair4_slot", cap4, e_fair4);
      cmp_seq("fair3_slot", cap3, e_fair3);
      seq_first(cap4, f);
      for (int i = 0; i < e_fair4.size(); i++)
         check("fair4_inst", (f >= 0 && f + i < capi4.size()) ? capi4[f + i] : 0, 32'hA0 + e_fair4[i]);

      do_reset();
      cap_clear();
      cap_en = 1'b1;
      v4 = 4'b1010;
      tick();
      v4 = 4'b1000;
      repeat (2) tick();
      v4 = 4'b0000;
      repeat (3) tick();
      cap_en = 1'b0;
      cmp_seq("early_release", cap4, e_early);

      do_reset();
      cap_clear();
      cap_en = 1'b1;
      out_ready = 1'b1;
      v4 = '1;
      tick();
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_req_ready", rr4, 0);
         check("bp_out_valid", ov4, 1);
         check("bp_out_inst", oi4, 32'hA0);
         check("bp_out_slot", os4, 0);
         tick();
      end
      out_ready = 1'b1;
      repeat (4) tick();
      cap_en = 1'b0;
      cmp_seq("bp_resume", cap4, e_bp);

      do_reset();
      cap_clear();
      cap_en = 1'b1;
      out_ready = 1'b1;
      v4 = '1;
      repeat (5) tick();
      flush = 1'b1;
      @(negedge clk);
      check("flush_no_grant", rr4, 0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("flush_out_valid", ov4, 0);
      repeat (4) tick();
      cap_en = 1'b0;
      cmp_seq("flush_seq", cap4, e_flush);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/inst_slot_arbiter.md
Name: inst_slot_arbiter

Overview:
- Round-robin scheduler that shares one instruction path between INPUT_SLOT requesters (fetch, replay, debug-inject and similar sources).
- Each requester presents an instruction with a valid/ready handshake.
- The arbiter picks a winner, steers it through a slot multiplexer and registers it into a one-entry output buffer toward decode.
- A bounded burst counter lets a winner keep the path for up to MAX_BURST consecutive beats before priority rotates.

Parameters:
- INPUT_SLOT, 4, number of requesters; must be ≥2.
- MAX_BURST, 2, maximum consecutive beats granted to one slot; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  INPUT_SLOT  per-slot instruction valid.
- req_inst  in  INPUT_SLOT×INST_LENGTH  per-slot instruction (packed array, slot 0 in lowest index).
- req_ready  out  INPUT_SLOT  per-slot accept; one-hot or zero.
- out_valid  out  1  output buffer holds an instruction.
- out_inst  out  INST_LENGTH  buffered instruction.
- out_slot  out  $clog2(INPUT_SLOT)  source slot of out_inst.
- out_ready  in  1  downstream accepts out_inst this cycle.
- flush  in  1  synchronous; drops buffer, resets burst state.

Behaviour:
- Reset (rst=1, asynchronous): out_valid=0, out_inst=0, out_slot=0, req_ready=0, priority pointer=0, burst count=0, FSM=IDLE.
- Transfer rule:
  - Slot i transfers when req_valid[i] & req_ready[i].
  - Output transfers when out_valid & out_ready.
- can_load = !out_valid | out_ready; buffer drains and refills in the same cycle (full throughput, 1 beat/cycle).
- req_ready is combinational from state and req_valid. It is 0 for all slots when !can_load or flush. req_valid must not depend on req_ready.
- Latency: an accepted beat appears at out_valid on the next cycle.
- FSM states:
  - IDLE: no owner.
    - If can_load and any req_valid: grant the first valid slot searching from pointer upward with wrap (pointer, pointer+1 … INPUT_SLOT-1, 0 …).
    - Load buffer; burst=1.
    - If MAX_BURST>1 go OWN, else pointer=winner+1 (mod INPUT_SLOT) and stay IDLE.
  - OWN: owner slot held in a register.
    - If can_load and req_valid[owner]: grant owner, burst+1. When burst reaches MAX_BURST: pointer=owner+1 mod INPUT_SLOT and return to IDLE.
    - If can_load and !req_valid[owner]: release. pointer=owner+1 and behave as IDLE in that same cycle (another slot may be granted with no bubble).
    - If !can_load: hold; the burst count does not advance.
- Wrap: pointer increments modulo INPUT_SLOT; non-power-of-two INPUT_SLOT is legal (pointer INPUT_SLOT-1 wraps to 0).
- Data steering:
  - The granted index drives the multiplexer select.
  - out_inst loads from the multiplexer output; out_slot loads the granted index.
  - When out_valid=0 these registers hold their last value; they are not X.
- flush (priority over everything except rst):
  - out_valid←0, FSM←IDLE, burst←0; pointer unchanged.
  - No grant is issued that cycle, even when out_ready=1.
- Simultaneous out_ready and new grant: the old beat leaves and the new beat loads; out_valid stays 1.
- Reset mid-burst: all state is cleared immediately; the first grant after rst deasserts searches from slot 0.
- Assertions:
  - req_ready is one-hot0.
  - out_inst and out_slot are stable while out_valid & !out_ready.
  - No grant while !can_load.

Decomposition:
- RVS192_package / RVS192_user_parameters keep INST_LENGTH. Add there:
  - typedef enum {ARB_IDLE, ARB_OWN} arb_state_e;
  - default constant MAX_BURST_DEF=2.
- Sub-module: instantiate Configurable_Multiplexer with INPUT_SLOT passed through, sel = granted index, data_in = req_inst.
- Round-robin search stays inline (one function).

Test Plan:
- Reset: assert rst mid-traffic → out_valid=0, req_ready=0 within the same cycle. After release, with all slots valid, the first grant goes to slot 0.
- Fairness, INPUT_SLOT=4, MAX_BURST=2, all slots valid, out_ready=1:
  - out_slot sequence is 0,0,1,1,2,2,3,3,0.
  - Instructions are 0xA0+slot; out_inst matches source.
- Early release: slot 1 valid for one beat only, slot 3 valid → out_slot sequence 1,3,3 with no idle cycle between 1 and 3.
- Backpressure: out_ready=0 for 3 cycles with the buffer full.
  - req_ready=0 throughout; out_inst stable; burst count frozen.
  - After out_ready=1, the owner resumes and completes its burst.
- Flush: assert flush during OWN on slot 2 with out_valid=1.
  - Next cycle out_valid=0, no grant that cycle.
  - Following grant searches from the unchanged pointer (slot 2 if still valid).
- Non-power-of-two: INPUT_SLOT=3, MAX_BURST=1, all valid → out_slot 0,1,2,0,1, and the pointer never reaches 3.
